// File: rtl/mold_pkg.sv
// Shared types and constants for the MoldUDP64 retransmission request generator.
// The wire layout of one 20-byte request is captured by req_beat().
package mold_pkg;

   localparam int MOLD_SEQ_NUM_W = 64;
   localparam int MOLD_SID_W     = 80;
   localparam int MOLD_ML_W      = 16;
   localparam int MOLD_REQ_BYTES = 20;
   localparam int MOLD_REQ_BEATS = 3;

   localparam logic [7:0] B2_KEEP = 8'h0F;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_B0,
      ST_B1,
      ST_B2
   } retx_fsm_e;

   typedef struct packed {
      logic [MOLD_SID_W-1:0]     sid;
      logic [MOLD_SEQ_NUM_W-1:0] seq;
      logic [MOLD_SEQ_NUM_W-1:0] cnt;
   } miss_rpt_t;

   // Beat `beat` of the big-endian message {sid, seq, cnt}; byte lane 0 leaves first.
   function automatic logic [63:0] req_beat(input int                        beat,
                                            input logic [MOLD_SID_W-1:0]     sid,
                                            input logic [MOLD_SEQ_NUM_W-1:0] seq,
                                            input logic [MOLD_ML_W-1:0]      cnt);
      logic [MOLD_REQ_BYTES*8-1:0] msg;
      logic [63:0]                 data;
      int                          idx;
      msg  = {sid, seq, cnt};
      data = '0;
      for (int lane = 0; lane < 8; lane++) begin
         idx = beat * 8 + lane;
         if (idx < MOLD_REQ_BYTES) data[lane*8 +: 8] = msg[(MOLD_REQ_BYTES-1-idx)*8 +: 8];
      end
      return data;
   endfunction

endpackage

// File: rtl/miss_rpt_fifo.sv
// Synchronous FIFO of miss reports; a push is accepted while full when a pop
// happens in the same cycle.
module miss_rpt_fifo
   import mold_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic      clk,
   input  logic      nreset,
   input  logic      push_i,
   input  logic      pop_i,
   input  miss_rpt_t rpt_i,
   output logic      full_o,
   output logic      empty_o,
   output miss_rpt_t head_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;

   miss_rpt_t     mem_q [DEPTH];
   logic [AW:0]   wr_ptr_q, wr_ptr_d;
   logic [AW:0]   rd_ptr_q, rd_ptr_d;
   logic          do_push, do_pop;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // NOTE: storage is not reset; the pointers alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= rpt_i;
   end

endmodule

// File: rtl/mold_retx_req_gen.sv
// MoldUDP64 retransmission request generator: buffers miss reports and emits
// 20-byte requests as 3 beats. Optional MOLD_RETX_DROP_CNT_EN adds drop_cnt_o.
module mold_retx_req_gen
   import mold_pkg::*;
#(
   parameter int                SEQ_NUM_W   = 64,
   parameter int                SID_W       = 80,
   parameter int                ML_W        = 16,
   parameter logic [ML_W-1:0]   MAX_REQ_CNT = 16'd255,
   parameter int                FIFO_DEPTH  = 4
) (
   input  logic                 clk,
   input  logic                 nreset,
   input  logic                 miss_v_i,
   input  logic [SID_W-1:0]     miss_sid_i,
   input  logic [SEQ_NUM_W-1:0] miss_seq_start_i,
   input  logic [SEQ_NUM_W-1:0] miss_seq_cnt_i,
   output logic                 req_valid_o,
   input  logic                 req_ready_i,
   output logic [63:0]          req_data_o,
   output logic [7:0]           req_keep_o,
   output logic                 req_last_o,
   output logic                 drop_o
`ifdef MOLD_RETX_DROP_CNT_EN
   ,
   output logic [31:0]          drop_cnt_o
`endif
);

   localparam logic [SEQ_NUM_W-1:0] MAX_N = SEQ_NUM_W'(MAX_REQ_CNT);

   retx_fsm_e            state_q, state_d;
   logic [SID_W-1:0]     cur_sid_q, cur_sid_d;
   logic [SEQ_NUM_W-1:0] cur_seq_q, cur_seq_d;
   logic [SEQ_NUM_W-1:0] cur_rem_q, cur_rem_d;
   logic [ML_W-1:0]      n_cur, n_out;

   logic                 valid_q, valid_d;
   logic [63:0]          data_q, data_d;
   logic [7:0]           keep_q, keep_d;
   logic                 last_q, last_d;
   logic                 drop_q, drop_d;

   logic                 push_req, fifo_pop, fifo_full, fifo_empty;
   miss_rpt_t            fifo_head, fifo_in;

   assign push_req = miss_v_i && (miss_seq_cnt_i != '0);
   assign drop_d   = push_req && fifo_full && !fifo_pop;
   assign fifo_in  = '{sid: miss_sid_i, seq: miss_seq_start_i, cnt: miss_seq_cnt_i};

   miss_rpt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .nreset  (nreset),
      .push_i  (push_req),
      .pop_i   (fifo_pop),
      .rpt_i   (fifo_in),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .head_o  (fifo_head)
   );

   assign n_cur = (cur_rem_q < MAX_N) ? cur_rem_q[ML_W-1:0] : MAX_REQ_CNT;

   // Next-state: B2 acceptance either continues the split, reloads from the FIFO, or idles.
   always_comb begin
      state_d   = state_q;
      cur_sid_d = cur_sid_q;
      cur_seq_d = cur_seq_q;
      cur_rem_d = cur_rem_q;
      fifo_pop  = 1'b0;
      unique case (state_q)
         ST_IDLE: if (!fifo_empty) begin
            fifo_pop = 1'b1;
            state_d  = ST_B0;
         end
         ST_B0: if (req_ready_i) state_d = ST_B1;
         ST_B1: if (req_ready_i) state_d = ST_B2;
         ST_B2: if (req_ready_i) begin
            cur_seq_d = cur_seq_q + SEQ_NUM_W'(n_cur);
            cur_rem_d = cur_rem_q - SEQ_NUM_W'(n_cur);
            if (cur_rem_q != SEQ_NUM_W'(n_cur)) begin
               state_d = ST_B0;
            end else if (!fifo_empty) begin
               fifo_pop = 1'b1;
               state_d  = ST_B0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (fifo_pop) begin
         cur_sid_d = fifo_head.sid;
         cur_seq_d = fifo_head.seq;
         cur_rem_d = fifo_head.cnt;
      end
   end

   // Outputs are computed from the next state so the registered beat matches state_q.
   always_comb begin
      n_out   = (cur_rem_d < MAX_N) ? cur_rem_d[ML_W-1:0] : MAX_REQ_CNT;
      valid_d = 1'b0;
      data_d  = '0;
      keep_d  = '0;
      last_d  = 1'b0;
      unique case (state_d)
         ST_B0: begin
            valid_d = 1'b1;
            data_d  = req_beat(0, cur_sid_d, cur_seq_d, n_out);
            keep_d  = 8'hFF;
         end
         ST_B1: begin
            valid_d = 1'b1;
            data_d  = req_beat(1, cur_sid_d, cur_seq_d, n_out);
            keep_d  = 8'hFF;
         end
         ST_B2: begin
            valid_d = 1'b1;
            data_d  = req_beat(2, cur_sid_d, cur_seq_d, n_out);
            keep_d  = B2_KEEP;
            last_d  = 1'b1;
         end
         default: ;
      endcase
   end

   // NOTE: every flop here uses <= so all updates see the pre-edge values.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_q   <= ST_IDLE;
         cur_sid_q <= '0;
         cur_seq_q <= '0;
         cur_rem_q <= '0;
         valid_q   <= 1'b0;
         data_q    <= '0;
         keep_q    <= '0;
         last_q    <= 1'b0;
         drop_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cur_sid_q <= cur_sid_d;
         cur_seq_q <= cur_seq_d;
         cur_rem_q <= cur_rem_d;
         valid_q   <= valid_d;
         data_q    <= data_d;
         keep_q    <= keep_d;
         last_q    <= last_d;
         drop_q    <= drop_d;
      end
   end

   assign req_valid_o = valid_q;
   assign req_data_o  = data_q;
   assign req_keep_o  = keep_q;
   assign req_last_o  = last_q;
   assign drop_o      = drop_q;

`ifdef MOLD_RETX_DROP_CNT_EN
   logic [31:0] drop_cnt_q, drop_cnt_d;

   assign drop_cnt_d = (drop_d && (drop_cnt_q != '1)) ? drop_cnt_q + 32'd1 : drop_cnt_q;

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) drop_cnt_q <= '0;
      else         drop_cnt_q <= drop_cnt_d;
   end

   assign drop_cnt_o = drop_cnt_q;
`endif

endmodule

// File: tb/tb_mold_retx_req_gen.sv
// Self-checking bench for mold_retx_req_gen: directed and randomized reports
// compared against a byte-level request model.
module tb_mold_retx_req_gen;

   logic        clk = 1'b0;
   logic        nreset;
   logic        miss_v_i;
   logic [79:0] miss_sid_i;
   logic [63:0] miss_seq_start_i;
   logic [63:0] miss_seq_cnt_i;
   logic        req_valid_o;
   logic        req_ready_i;
   logic [63:0] req_data_o;
   logic [7:0]  req_keep_o;
   logic        req_last_o;
   logic        drop_o;
`ifdef MOLD_RETX_DROP_CNT_EN
   logic [31:0] drop_cnt_o;
`endif

   mold_retx_req_gen dut (
      .clk              (clk),
      .nreset           (nreset),
      .miss_v_i         (miss_v_i),
      .miss_sid_i       (miss_sid_i),
      .miss_seq_start_i (miss_seq_start_i),
      .miss_seq_cnt_i   (miss_seq_cnt_i),
      .req_valid_o      (req_valid_o),
      .req_ready_i      (req_ready_i),
      .req_data_o       (req_data_o),
      .req_keep_o       (req_keep_o),
      .req_last_o       (req_last_o),
      .drop_o           (drop_o)
`ifdef MOLD_RETX_DROP_CNT_EN
      ,
      .drop_cnt_o       (drop_cnt_o)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] data;
      logic [7:0]  keep;
      logic        last;
   } beat_t;

   beat_t exp_q[$];
   beat_t got_q[$];
   int    got_cyc[$];
   int    checks = 0;
   int    failures = 0;
   int    cyc = 0;
   int    stab_err = 0;
   int    last_span = 0;
   bit    rand_ready = 1'b0;

   beat_t mon_b;
   beat_t prev_b;
   bit    prev_hold = 1'b0;

   // Beats accepted downstream, plus a check that stalled beats do not change.
   always @(negedge clk) begin
      cyc++;
      if (nreset && prev_hold && req_valid_o) begin
         if (req_data_o !== prev_b.data || req_keep_o !== prev_b.keep || req_last_o !== prev_b.last)
            stab_err++;
      end
      if (prev_hold && nreset && !req_valid_o) stab_err++;
      prev_hold   = nreset && req_valid_o && !req_ready_i;
      prev_b.data = req_data_o;
      prev_b.keep = req_keep_o;
      prev_b.last = req_last_o;
      if (nreset && req_valid_o && req_ready_i) begin
         mon_b.data = req_data_o;
         mon_b.keep = req_keep_o;
         mon_b.last = req_last_o;
         got_q.push_back(mon_b);
         got_cyc.push_back(cyc);
      end
   end

   task automatic check_eq(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Reference: split the report into requests of at most 255 messages, lay out
   // each as 20 big-endian bytes padded to 24, and cut into 8-byte beats.
   function automatic void model_report(input logic [79:0] sid, input logic [63:0] seq,
                                        input logic [63:0] cnt);
      logic [7:0]  bytes [24];
      logic [63:0] n;
      beat_t       b;
      while (cnt != 0) begin
         n = (cnt > 64'd255) ? 64'd255 : cnt;
         for (int k = 0; k < 10; k++) bytes[k] = 8'(sid >> (8 * (9 - k)));
         for (int k = 0; k < 8; k++) bytes[10+k] = 8'(seq >> (8 * (7 - k)));
         bytes[18] = 8'(n >> 8);
         bytes[19] = 8'(n);
         for (int k = 20; k < 24; k++) bytes[k] = 8'h00;
         for (int bt = 0; bt < 3; bt++) begin
            b.data = '0;
            for (int lane = 0; lane < 8; lane++) b.data[lane*8 +: 8] = bytes[bt*8 + lane];
            b.keep = (bt == 2) ? 8'h0F : 8'hFF;
            b.last = (bt == 2);
            exp_q.push_back(b);
         end
         seq = seq + n;
         cnt = cnt - n;
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      if (rand_ready) req_ready_i = 1'($urandom_range(0, 1));
   endtask

   task automatic push(input logic [79:0] sid, input logic [63:0] seq, input logic [63:0] cnt);
      miss_v_i         = 1'b1;
      miss_sid_i       = sid;
      miss_seq_start_i = seq;
      miss_seq_cnt_i   = cnt;
      tick();
      miss_v_i = 1'b0;
   endtask

   task automatic drain(input string tag);
      int budget = 3000;
      while (got_q.size() < exp_q.size() && budget > 0) begin
         tick();
         budget--;
      end
      repeat (6) tick();
      check_eq({tag, "_beat_count"}, 64'(got_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         check_eq($sformatf("%s_data[%0d]", tag, i), got_q[i].data, exp_q[i].data);
         check_eq($sformatf("%s_keep[%0d]", tag, i), 64'(got_q[i].keep), 64'(exp_q[i].keep));
         check_eq($sformatf("%s_last[%0d]", tag, i), 64'(got_q[i].last), 64'(exp_q[i].last));
      end
      last_span = (got_cyc.size() > 0) ? got_cyc[$] - got_cyc[0] : -1;
      exp_q.delete();
      got_q.delete();
      got_cyc.delete();
   endtask

   task automatic check_outputs_zero(input string tag);
      check_eq({tag, "_valid"}, 64'(req_valid_o), 64'd0);
      check_eq({tag, "_data"},  req_data_o,        64'd0);
      check_eq({tag, "_keep"},  64'(req_keep_o),   64'd0);
      check_eq({tag, "_last"},  64'(req_last_o),   64'd0);
      check_eq({tag, "_drop"},  64'(drop_o),       64'd0);
   endtask

   initial begin
      logic [79:0] sid;
      logic [63:0] seq;
      logic [63:0] cnt;
      int          vcount;

      nreset           = 1'b0;
      miss_v_i         = 1'b0;
      miss_sid_i       = '0;
      miss_seq_start_i = '0;
      miss_seq_cnt_i   = '0;
      req_ready_i      = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check_outputs_zero("reset");
`ifdef MOLD_RETX_DROP_CNT_EN
      check_eq("reset_drop_cnt", 64'(drop_cnt_o), 64'd0);
`endif
      nreset = 1'b1;
      tick();

      // Single report with exact beat values and latency
      req_ready_i = 1'b1;
      push(80'h1, 64'd5, 64'd3);
      model_report(80'h1, 64'd5, 64'd3);
      check_eq("single_valid_n1", 64'(req_valid_o), 64'd0);
      tick();
      check_eq("single_valid_n2", 64'(req_valid_o), 64'd1);
      check_eq("single_b0_data", req_data_o, 64'h0);
      check_eq("single_b0_keep", 64'(req_keep_o), 64'hFF);
      tick();
      check_eq("single_b1_data", req_data_o, 64'h0000_0000_0000_0100);
      check_eq("single_b1_keep", 64'(req_keep_o), 64'hFF);
      check_eq("single_b1_last", 64'(req_last_o), 64'd0);
      tick();
      check_eq("single_b2_data", req_data_o, 64'h0000_0000_0300_0500);
      check_eq("single_b2_keep", 64'(req_keep_o), 64'h0F);
      check_eq("single_b2_last", 64'(req_last_o), 64'd1);
      tick();
      check_eq("single_idle_after", 64'(req_valid_o), 64'd0);
      drain("single");

      // Split into 255/255/90, back-to-back
      sid = 80'h1234_5678_9ABC_DEF0_1122;
      push(sid, 64'd1000, 64'd600);
      model_report(sid, 64'd1000, 64'd600);
      drain("split");
      check_eq("split_no_bubble", 64'(last_span), 64'd8);

      // Sequence number wrap
      sid = 80'hAA;
      push(sid, 64'hFFFF_FFFF_FFFF_FFFF, 64'd300);
      model_report(sid, 64'hFFFF_FFFF_FFFF_FFFF, 64'd300);
      drain("wrap");

      // Random backpressure with random reports
      rand_ready = 1'b1;
      stab_err   = 0;
      for (int r = 0; r < 3; r++) begin
         sid = 80'({$urandom(), $urandom(), $urandom()});
         seq = {$urandom(), $urandom()};
         cnt = 64'($urandom_range(1, 600));
         push(sid, seq, cnt);
         model_report(sid, seq, cnt);
      end
      drain("bp");
      check_eq("bp_stable", 64'(stab_err), 64'd0);
      rand_ready  = 1'b0;
      req_ready_i = 1'b1;
      tick();

      // Overflow: one report in the FSM, four in the FIFO, sixth dropped
      req_ready_i = 1'b0;
      for (int r = 0; r < 6; r++) begin
         sid = 80'(r + 16);
         seq = 64'(1000 * (r + 1));
         cnt = 64'($urandom_range(1, 300));
         push(sid, seq, cnt);
         if (r < 5) begin
            model_report(sid, seq, cnt);
            check_eq($sformatf("ovf_nodrop_%0d", r), 64'(drop_o), 64'd0);
         end else begin
            check_eq("ovf_drop_pulse", 64'(drop_o), 64'd1);
         end
      end
      push(80'h99, 64'd7, 64'd0);
      check_eq("ovf_zero_cnt_nodrop", 64'(drop_o), 64'd0);
`ifdef MOLD_RETX_DROP_CNT_EN
      check_eq("ovf_drop_cnt", 64'(drop_cnt_o), 64'd1);
`endif
      check_eq("ovf_hold_valid", 64'(req_valid_o), 64'd1);
      check_eq("ovf_hold_data", req_data_o, exp_q[0].data);
      req_ready_i = 1'b1;
      drain("ovf");

      // Reset during B1
      push(80'h5, 64'd77, 64'd10);
      tick();
      tick();
      check_eq("rst_mid_in_b1", req_data_o, 64'h0000_0000_0000_0500);
      nreset = 1'b0;
      #1;
      check_outputs_zero("rst_mid");
      exp_q.delete();
      got_q.delete();
      got_cyc.delete();
      tick();
      nreset = 1'b1;
      vcount = 0;
      repeat (10) begin
         tick();
         if (req_valid_o) vcount++;
      end
      check_eq("rst_quiet_after", 64'(vcount), 64'd0);
      push(80'h6, 64'd123, 64'd4);
      model_report(80'h6, 64'd123, 64'd4);
      drain("post_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
